// File: rtl/compute_unit_pkg.sv
// Shared opcode encodings, FSM state encoding and opcode helpers for the
// compute_unit_param block.
package compute_unit_pkg;

   typedef logic [2:0] op_t;
   typedef logic [1:0] state_t;

   localparam op_t OP_ADD  = 3'b000;
   localparam op_t OP_SUB  = 3'b001;
   localparam op_t OP_AND  = 3'b010;
   localparam op_t OP_OR   = 3'b011;
   localparam op_t OP_XOR  = 3'b100;
   localparam op_t OP_MAX  = 3'b101;
   localparam op_t OP_ACC  = 3'b110;
   localparam op_t OP_LOAD = 3'b111;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HAVE_A = 2'd1;
   localparam logic [1:0] ST_BUSY   = 2'd2;

   // ACC and LOAD take their single operand on the first capture.
   function automatic logic is_single_op(input op_t op);
      return (op == OP_ACC) || (op == OP_LOAD);
   endfunction

endpackage

// File: rtl/compute_unit_param_if.sv
// Capture-stream / result bus of compute_unit_param. The stimulus source
// uses the master modport, the compute unit the slave modport.
interface compute_unit_param_if
   import compute_unit_pkg::*;
#(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] d_in;
   op_t              op;
   logic             capture;
   logic             ready;
   logic             valid;
   logic [WIDTH:0]   result;
   logic             flag;
   logic             drop_err;

   modport master (
      output d_in, op, capture,
      input  ready, valid, result, flag, drop_err
   );

   modport slave (
      input  d_in, op, capture,
      output ready, valid, result, flag, drop_err
   );
endinterface

// File: rtl/compute_unit_param_delay_pipe.sv
// LATENCY-deep shift register carrying {vld, op, A, B/d} from the sampling
// edge to the ALU that sits at its output.
module result_delay_pipe
   import compute_unit_pkg::*;
#(
   parameter int DW      = 4,
   parameter int LATENCY = 1
) (
   input  logic          clock,
   input  logic          rst_n,
   input  logic          in_vld,
   input  op_t           in_op,
   input  logic [DW-1:0] in_a,
   input  logic [DW-1:0] in_b,
   output logic          out_vld,
   output op_t           out_op,
   output logic [DW-1:0] out_a,
   output logic [DW-1:0] out_b
);
   localparam int SW = 1 + 3 + 2 * DW;

   genvar gi;
   generate
      for (gi = 0; gi < LATENCY; gi++) begin : g_stage
         logic [SW-1:0] data_reg;
         if (gi == 0) begin : g_first
            always_ff @(posedge clock) begin
               if (!rst_n) data_reg <= '0;
               else        data_reg <= {in_vld, in_op, in_a, in_b};
            end
         end else begin : g_rest
            always_ff @(posedge clock) begin
               if (!rst_n) data_reg <= '0;
               else        data_reg <= g_stage[gi-1].data_reg;
            end
         end
      end
   endgenerate

   assign {out_vld, out_op, out_a, out_b} = g_stage[LATENCY-1].data_reg;

endmodule

// File: rtl/compute_unit_param.sv
// Two-operand / accumulate compute unit: collects operands from a capture
// stream, runs them through a delay pipe and registers the ALU result.
module compute_unit_param
   import compute_unit_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int LATENCY = 1
) (
   input  logic          clock,
   input  logic          rst_n,
   compute_unit_param_if.slave bus
);
   state_t           state_reg, state_next;
   op_t              op_reg, op_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic [WIDTH:0]   acc_reg, acc_next;
   logic [WIDTH:0]   result_reg, result_next;
   logic             flag_reg, flag_next;
   logic             drop_reg, drop_next;
   logic             valid_reg;
   logic             ready;

   logic             in_vld;
   op_t              in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             p_vld;
   op_t              p_op;
   logic [WIDTH-1:0] p_a;
   logic [WIDTH-1:0] p_b;

   logic [WIDTH:0]   a_x;
   logic [WIDTH:0]   b_x;
   logic [WIDTH+1:0] acc_sum;
   logic [WIDTH:0]   alu_res;
   logic             alu_flag;

   assign ready = (state_reg != ST_BUSY);

   result_delay_pipe #(
      .DW      (WIDTH),
      .LATENCY (LATENCY)
   ) u_pipe (
      .clock   (clock),
      .rst_n   (rst_n),
      .in_vld  (in_vld),
      .in_op   (in_op),
      .in_a    (in_a),
      .in_b    (in_b),
      .out_vld (p_vld),
      .out_op  (p_op),
      .out_a   (p_a),
      .out_b   (p_b)
   );

   // Operand collection; the pipe is launched on the capture completing a transaction.
   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      a_next     = a_reg;
      drop_next  = drop_reg;
      in_vld     = 1'b0;
      in_op      = op_reg;
      in_a       = a_reg;
      in_b       = bus.d_in;

      if (bus.capture && !ready) drop_next = 1'b1;

      case (state_reg)
         ST_IDLE: begin
            if (bus.capture) begin
               op_next = bus.op;
               if (is_single_op(bus.op)) begin
                  in_vld     = 1'b1;
                  in_op      = bus.op;
                  in_a       = '0;
                  state_next = ST_BUSY;
               end else begin
                  a_next     = bus.d_in;
                  state_next = ST_HAVE_A;
               end
            end
         end
         ST_HAVE_A: begin
            if (bus.capture) begin
               in_vld     = 1'b1;
               state_next = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (p_vld) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign a_x     = {1'b0, p_a};
   assign b_x     = {1'b0, p_b};
   assign acc_sum = {1'b0, acc_reg} + {2'b00, p_b};

   always_comb begin
      alu_res  = '0;
      alu_flag = 1'b0;
      case (p_op)
         OP_ADD:  alu_res = a_x + b_x;
         OP_SUB: begin
            alu_res  = a_x - b_x;
            alu_flag = (p_a < p_b);
         end
         OP_AND:  alu_res = a_x & b_x;
         OP_OR:   alu_res = a_x | b_x;
         OP_XOR:  alu_res = a_x ^ b_x;
         OP_MAX: begin
            alu_res  = (p_b > p_a) ? b_x : a_x;
            alu_flag = (p_b > p_a);
         end
         OP_ACC: begin
            alu_res  = acc_sum[WIDTH:0];
            alu_flag = acc_sum[WIDTH+1];
         end
         default: alu_res = b_x;
      endcase
   end

   always_comb begin
      result_next = result_reg;
      flag_next   = flag_reg;
      acc_next    = acc_reg;
      if (p_vld) begin
         result_next = alu_res;
         flag_next   = alu_flag;
         if (is_single_op(p_op)) acc_next = alu_res;
      end
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_reg  <= ST_IDLE;
         op_reg     <= OP_ADD;
         a_reg      <= '0;
         acc_reg    <= '0;
         result_reg <= '0;
         flag_reg   <= 1'b0;
         drop_reg   <= 1'b0;
         valid_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         op_reg     <= op_next;
         a_reg      <= a_next;
         acc_reg    <= acc_next;
         result_reg <= result_next;
         flag_reg   <= flag_next;
         drop_reg   <= drop_next;
         valid_reg  <= p_vld;
      end
   end

   assign bus.ready    = ready;
   assign bus.valid    = valid_reg;
   assign bus.result   = result_reg;
   assign bus.flag     = flag_reg;
   assign bus.drop_err = drop_reg;

endmodule

// File: tb/tb_compute_unit_param.sv
// Self-checking bench: three instances (W4/L1, W4/L3, W8/L1), table-driven
// transactions checked through a scoreboard, plus drop and reset sequences.
module tb_compute_unit_param;
   import compute_unit_pkg::*;

   logic        clock = 1'b0;
   logic        rst_n;
   logic        cap_s;
   logic [2:0]  op_s;
   logic [15:0] d_s;
   int          sel;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   compute_unit_param_if #(.WIDTH(4)) bus0 ();
   compute_unit_param_if #(.WIDTH(4)) bus1 ();
   compute_unit_param_if #(.WIDTH(8)) bus2 ();

   assign bus0.capture = cap_s && (sel == 0);
   assign bus1.capture = cap_s && (sel == 1);
   assign bus2.capture = cap_s && (sel == 2);
   assign bus0.op   = op_s;
   assign bus1.op   = op_s;
   assign bus2.op   = op_s;
   assign bus0.d_in = d_s[3:0];
   assign bus1.d_in = d_s[3:0];
   assign bus2.d_in = d_s[7:0];

   compute_unit_param #(.WIDTH(4), .LATENCY(1)) dut0 (.clock(clock), .rst_n(rst_n), .bus(bus0));
   compute_unit_param #(.WIDTH(4), .LATENCY(3)) dut1 (.clock(clock), .rst_n(rst_n), .bus(bus1));
   compute_unit_param #(.WIDTH(8), .LATENCY(1)) dut2 (.clock(clock), .rst_n(rst_n), .bus(bus2));

   logic        v [3];
   logic        rdy [3];
   logic        flg [3];
   logic        de [3];
   logic [16:0] res [3];

   assign v[0] = bus0.valid;   assign v[1] = bus1.valid;   assign v[2] = bus2.valid;
   assign rdy[0] = bus0.ready; assign rdy[1] = bus1.ready; assign rdy[2] = bus2.ready;
   assign flg[0] = bus0.flag;  assign flg[1] = bus1.flag;  assign flg[2] = bus2.flag;
   assign de[0] = bus0.drop_err; assign de[1] = bus1.drop_err; assign de[2] = bus2.drop_err;
   assign res[0] = 17'(bus0.result);
   assign res[1] = 17'(bus1.result);
   assign res[2] = 17'(bus2.result);

   typedef struct {
      int          sel;
      int          exp_cyc;
      logic [16:0] res;
      logic        flag;
   } exp_t;
   exp_t sb [$];
   exp_t mon_e;

   typedef struct {
      int          sel;
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [16:0] res;
      logic        flag;
   } vec_t;
   vec_t tv [17];

   function automatic int lat_of(input int k);
      return (k == 1) ? 3 : 1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      for (int k = 0; k < 3; k++) begin
         if (v[k] === 1'b1) begin
            if (sb.size() == 0) begin
               chk($sformatf("unexpected_valid_dut%0d", k), 32'd1, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               $display("txn dut%0d cyc=%0d result=%0h flag=%0b", k, cyc, res[k], flg[k]);
               chk("valid_dut", k, mon_e.sel);
               chk("result", 32'(res[k]), 32'(mon_e.res));
               chk("flag", 32'(flg[k]), 32'(mon_e.flag));
               chk("latency", cyc, mon_e.exp_cyc);
               chk("ready_in_valid", 32'(rdy[k]), 32'd1);
            end
         end
      end
   end

   task automatic cap(input int s, input logic [2:0] op, input logic [15:0] d, output int c);
      int guard;
      guard = 0;
      while (rdy[s] !== 1'b1 && guard < 40) begin
         cap_s = 1'b0;
         @(negedge clock);
         guard++;
      end
      if (guard >= 40) chk("ready_timeout", 32'd0, 32'd1);
      sel   = s;
      cap_s = 1'b1;
      op_s  = op;
      d_s   = d;
      c     = cyc;
      @(negedge clock);
   endtask

   task automatic run_txn(input int s, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [16:0] r, input logic f);
      int c;
      exp_t e;
      if (is_single_op(op)) begin
         cap(s, op, b, c);
      end else begin
         cap(s, op, a, c);
         cap(s, ~op, b, c);
      end
      e.sel = s; e.exp_cyc = c + 1 + lat_of(s); e.res = r; e.flag = f;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      cap_s = 1'b0;
      repeat (n) @(negedge clock);
   endtask

   task automatic drain();
      int g;
      g = 0;
      cap_s = 1'b0;
      while (sb.size() > 0 && g < 50) begin
         @(negedge clock);
         g++;
      end
      chk("drain", sb.size(), 0);
   endtask

   task automatic pulse_reset();
      cap_s = 1'b0;
      rst_n = 1'b0;
      @(negedge clock);
      rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      exp_t e;
      tv[0]  = '{0, OP_ADD,  16'd9,    16'd12,   17'd21,    1'b0};
      tv[1]  = '{0, OP_SUB,  16'd3,    16'd5,    17'd30,    1'b1};
      tv[2]  = '{0, OP_MAX,  16'd7,    16'd7,    17'd7,     1'b0};
      tv[3]  = '{0, OP_LOAD, 16'd0,    16'd15,   17'd15,    1'b0};
      tv[4]  = '{0, OP_ACC,  16'd0,    16'd15,   17'd30,    1'b0};
      tv[5]  = '{0, OP_ACC,  16'd0,    16'd15,   17'd13,    1'b1};
      tv[6]  = '{0, OP_AND,  16'd12,   16'd10,   17'd8,     1'b0};
      tv[7]  = '{0, OP_OR,   16'd12,   16'd3,    17'd15,    1'b0};
      tv[8]  = '{0, OP_XOR,  16'd9,    16'd5,    17'd12,    1'b0};
      tv[9]  = '{0, OP_MAX,  16'd3,    16'd9,    17'd9,     1'b1};
      tv[10] = '{0, OP_SUB,  16'd15,   16'd15,   17'd0,     1'b0};
      tv[11] = '{2, OP_ADD,  16'd255,  16'd255,  17'd510,   1'b0};
      tv[12] = '{2, OP_XOR,  16'h00AA, 16'h000F, 17'h0A5,   1'b0};
      tv[13] = '{2, OP_SUB,  16'd0,    16'd1,    17'd511,   1'b1};
      tv[14] = '{2, OP_ACC,  16'd0,    16'd200,  17'd200,   1'b0};
      tv[15] = '{2, OP_ACC,  16'd0,    16'd200,  17'd400,   1'b0};
      tv[16] = '{2, OP_MAX,  16'h0080, 16'h007F, 17'h080,   1'b0};

      rst_n = 1'b0; cap_s = 1'b0; sel = 0; op_s = 3'd0; d_s = 16'd0;
      repeat (3) @(negedge clock);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_ready", 32'(rdy[k]), 32'd1);
         chk("rst_valid", 32'(v[k]), 32'd0);
         chk("rst_result", 32'(res[k]), 32'd0);
         chk("rst_flag", 32'(flg[k]), 32'd0);
         chk("rst_drop", 32'(de[k]), 32'd0);
      end

      // Back-to-back table run: each next capture waits only for ready.
      for (int i = 0; i < 17; i++)
         run_txn(tv[i].sel, tv[i].op, tv[i].a, tv[i].b, tv[i].res, tv[i].flag);
      drain();
      idle(3);
      chk("held_result", 32'(res[2]), 32'h80);
      chk("held_result0", 32'(res[0]), 32'd0);

      // Capture while BUSY on the latency-3 instance.
      cap(1, OP_ADD, 16'd1, c);
      cap(1, OP_SUB, 16'd2, c);
      e.sel = 1; e.exp_cyc = c + 4; e.res = 17'd3; e.flag = 1'b0;
      sb.push_back(e);
      chk("busy_not_ready", 32'(rdy[1]), 32'd0);
      cap_s = 1'b1; op_s = OP_LOAD; d_s = 16'd9;
      @(negedge clock);
      cap_s = 1'b0;
      chk("drop_set", 32'(de[1]), 32'd1);
      drain();
      idle(4);
      chk("drop_sticky", 32'(de[1]), 32'd1);
      chk("drop_result_kept", 32'(res[1]), 32'd3);
      pulse_reset();
      chk("drop_cleared", 32'(de[1]), 32'd0);

      // Reset while HAVE_A.
      cap(0, OP_ADD, 16'd5, c);
      pulse_reset();
      chk("rstA_ready", 32'(rdy[0]), 32'd1);
      chk("rstA_result", 32'(res[0]), 32'd0);
      idle(6);

      // Reset while BUSY.
      cap(1, OP_ADD, 16'd1, c);
      cap(1, OP_ADD, 16'd2, c);
      pulse_reset();
      chk("rstB_ready", 32'(rdy[1]), 32'd1);
      chk("rstB_result", 32'(res[1]), 32'd0);
      chk("rstB_flag", 32'(flg[1]), 32'd0);
      idle(8);

      // After reset the FSM starts in IDLE and acc is zero.
      run_txn(0, OP_ADD, 16'd2, 16'd3, 17'd5, 1'b0);
      run_txn(0, OP_ACC, 16'd0, 16'd3, 17'd3, 1'b0);
      run_txn(2, OP_ACC, 16'd0, 16'd7, 17'd7, 1'b0);
      drain();
      idle(3);
      chk("sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/compute_unit_param.md
Name: compute_unit_param

Overview:
Parametrised two-operand/accumulate computation unit driven by a serial capture stream of {capture, op, d_in}. It collects operands over successive capture pulses, executes one of eight ops, and presents a (WIDTH+1)-bit result with a one-cycle valid pulse after a configurable pipeline latency. It also adds a running accumulator, a busy/ready indication and a sticky dropped-capture error. Stimulus vectors for the tb player are 1+3+WIDTH bits wide, packed {capture, op[2:0], d_in}.

Parameters:
WIDTH, 4, operand width in bits (legal 2..16)
LATENCY, 1, cycles from the clock edge that samples the last operand to the valid edge (legal 1..4)

Ports:
clock  in  1  system clock, all state updates on rising edge
rst_n  in  1  reset; one clock; synchronous, active-low
d_in  in  WIDTH  operand data, sampled when capture=1 and ready=1
op  in  3  opcode, sampled only on the first capture of a transaction
capture  in  1  operand strobe, one operand per high cycle
ready  out  1  1 = a capture this cycle is accepted
valid  out  1  one-cycle pulse: result/flag updated this cycle
result  out  WIDTH+1  result of the last completed op, held until the next valid
flag  out  1  borrow/carry qualifier of the last result, held with result
drop_err  out  1  sticky: a capture arrived while ready=0

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; A, B, acc, result, flag cleared to 0; valid=0; ready=1; drop_err=0; in-flight pipeline entries discarded. Reset mid-transaction has the same effect; no valid is emitted afterwards for that transaction.
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MAX, 110 ACC, 111 LOAD.
- FSM states: IDLE, HAVE_A, BUSY.
- IDLE + capture: latch op. If op is ACC or LOAD, this is a single-operand transaction: go to BUSY and start the pipeline with d_in. Otherwise A<=d_in and go to HAVE_A.
- HAVE_A + capture: B<=d_in and go to BUSY. The op input is ignored on this capture. No timeout; HAVE_A waits indefinitely.
- BUSY: ready=0. After LATENCY edges from the sampling edge, valid=1 for exactly one cycle, result/flag update and state=IDLE. ready=1 is already asserted in the valid cycle, so back-to-back transactions are allowed.
- ready=1 in IDLE and HAVE_A.
- Capture with ready=0 is ignored: no state change and drop_err<=1 until reset.
- Arithmetic (all zero-extended to WIDTH+1):
  - ADD: A+B, flag=0.
  - SUB: (A-B) mod 2^(WIDTH+1), flag=(A<B).
  - AND/OR/XOR: bitwise, flag=0.
  - MAX: larger unsigned value, flag=(B>A).
  - ACC: acc<=(acc+d) mod 2^(WIDTH+1), result=new acc, flag=carry out of bit WIDTH.
  - LOAD: acc<=d, result=d, flag=0.
- acc is updated in the same cycle valid asserts. It persists across other ops and is cleared only by reset.
- valid and result never change except as above. result is stable whenever valid=0.

Decomposition:
- Package compute_unit_pkg: opcode localparams (OP_ADD..OP_LOAD), FSM state typedef/encoding, helper function is_single_op(op).
- One sub-module, result_delay_pipe #(DW, LATENCY): shift register carrying {vld, op, A, B/d} LATENCY stages, cleared by rst_n. The ALU is evaluated at the pipe output.

Test Plan:
- WIDTH=4, LATENCY=1, ADD 9 then 12 -> valid 1 cycle after 2nd capture edge, result=5'b10101 (21), flag=0, ready high in valid cycle.
- SUB 3 then 5 -> result=5'b11110, flag=1. Then back-to-back MAX 7,7 (capture in the valid cycle accepted) -> result=7, flag=0.
- LOAD 15, ACC 15, ACC 15 -> results 15, 30, 13 with flag 0, 0, 1.
- LATENCY=3, capture during BUSY -> ignored, drop_err=1 and stays 1, completed result unchanged. Then reset -> drop_err=0.
- Reset asserted while in HAVE_A and again while BUSY -> no valid ever emitted, result=0, ready=1 next cycle, acc=0.
- WIDTH=8, ADD 255,255 -> result=9'd510. XOR 0xAA,0x0F -> 9'h0A5.
